// File: rtl/multiplier_iter_32b_pkg.sv
// ----------------------------------------------------------------------------
// tinyrv1_pkg
// Definitions shared by the TinyRV1 iterative multiplier and its datapath:
//   - imul_state_t : control FSM state encoding
//   - IMUL_NITERS  : number of shift-add iterations (one per multiplier bit)
//   - IMUL_CW      : width of the iteration counter
//   - mux2_32      : the common 2-input 32-bit mux used for register next-value
//                    selection (sel=0 -> in0, sel=1 -> in1)
// ----------------------------------------------------------------------------
package tinyrv1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } imul_state_t;

    localparam int IMUL_NITERS = 32;
    localparam int IMUL_CW     = $clog2(IMUL_NITERS);

    function automatic logic [31:0] mux2_32(
        input logic        sel,
        input logic [31:0] in0,
        input logic [31:0] in1
    );
        return sel ? in1 : in0;
    endfunction

endpackage

// File: rtl/multiplier_iter_32b_if.sv
// ----------------------------------------------------------------------------
// multiplier_iter_32b_if
// Operand and product streams of the iterative multiplier, each using a
// latency-insensitive val/rdy handshake.
//   istream_val  operands valid          (master -> slave)
//   istream_rdy  multiplier can accept    (slave  -> master)
//   in0          multiplicand, 32 bits    (master -> slave)
//   in1          multiplier, 32 bits      (master -> slave)
//   ostream_val  product valid            (slave  -> master)
//   ostream_rdy  consumer can take product(master -> slave)
//   out          product, low 32 bits     (slave  -> master)
// The multiplier itself is the slave; the control unit / testbench is the
// master of both streams.
// ----------------------------------------------------------------------------
interface multiplier_iter_32b_if;

    logic        istream_val;
    logic        istream_rdy;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [31:0] out;

    modport master (
        output istream_val,
        output in0,
        output in1,
        output ostream_rdy,
        input  istream_rdy,
        input  ostream_val,
        input  out
    );

    modport slave (
        input  istream_val,
        input  in0,
        input  in1,
        input  ostream_rdy,
        output istream_rdy,
        output ostream_val,
        output out
    );

endinterface

// File: rtl/multiplier_iter_32b_dpath.sv
// ----------------------------------------------------------------------------
// multiplier_iter_32b_dpath
// Shift-add datapath: multiplicand (a), multiplier (b), partial product
// (result) and iteration counter registers plus the adder and shifters.
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset, clears every register
//   load_i         capture operands, clear result and counter
//   shift_i        one iteration: a<<=1, b>>=1, count++
//   add_en_i       accumulate a into result this cycle
//   in0_i, in1_i   operands captured on load_i
//   b_lsb_o        current multiplier LSB (decides add_en_i)
//   count_done_o   current iteration is the last one
//   result_o       partial / final product
// ----------------------------------------------------------------------------
module multiplier_iter_32b_dpath
    import tinyrv1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        shift_i,
    input  logic        add_en_i,
    input  logic [31:0] in0_i,
    input  logic [31:0] in1_i,
    output logic        b_lsb_o,
    output logic        count_done_o,
    output logic [31:0] result_o
);

    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        result_q, result_d;
    logic [IMUL_CW-1:0] count_q, count_d;
    logic [31:0]        sum;

    // Carry-out is dropped: only the low 32 bits of the product are kept.
    assign sum = result_q + a_q;

    always_comb begin
        a_d      = mux2_32(load_i, mux2_32(shift_i, a_q, a_q << 1), in0_i);
        b_d      = mux2_32(load_i, mux2_32(shift_i, b_q, b_q >> 1), in1_i);
        result_d = mux2_32(load_i, mux2_32(add_en_i, result_q, sum), 32'd0);
        count_d  = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (shift_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

    assign b_lsb_o      = b_q[0];
    assign count_done_o = (count_q == IMUL_CW'(IMUL_NITERS - 1));
    assign result_o     = result_q;

endmodule

// File: rtl/multiplier_iter_32b.sv
// ----------------------------------------------------------------------------
// multiplier_iter_32b
// Iterative 32x32->32 shift-add multiplier for the TinyRV1 MUL instruction.
// Always runs the full 32 iterations, so an accepted operand pair produces
// ostream_val 33 cycles later. Only the low 32 bits of the product are
// returned, which is identical for signed and unsigned operands.
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset; abandons any operation in flight
//   io    slave side of the operand/product val/rdy streams
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for operands (istream_rdy=1)
// CALC  | 32 shift-add iterations, both streams stalled
// DONE  | product presented (ostream_val=1) until ostream_rdy
// ----------------------------------------------------------------------------
module multiplier_iter_32b
    import tinyrv1_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    multiplier_iter_32b_if.slave  io
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_CALC = CALC;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]  state_q, state_d;
    logic        load;
    logic        shift;
    logic        add_en;
    logic        b_lsb;
    logic        count_done;
    logic [31:0] result;
    logic        in_xfer;
    logic        out_xfer;

    // Handshake outputs are gated with rst so nothing is offered or accepted
    // while reset is held, even before the state register has cleared.
    assign io.istream_rdy = !rst && (state_q == S_IDLE);
    assign io.ostream_val = !rst && (state_q == S_DONE);
    assign io.out         = io.ostream_val ? result : 32'd0;

    assign in_xfer  = io.istream_val && io.istream_rdy;
    assign out_xfer = io.ostream_val && io.ostream_rdy;

    assign load   = in_xfer;
    assign shift  = (state_q == S_CALC);
    assign add_en = shift && b_lsb;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_xfer)    state_d = S_CALC;
            S_CALC: if (count_done) state_d = S_DONE;
            S_DONE: if (out_xfer)   state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    multiplier_iter_32b_dpath u_dpath (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .shift_i      (shift),
        .add_en_i     (add_en),
        .in0_i        (io.in0),
        .in1_i        (io.in1),
        .b_lsb_o      (b_lsb),
        .count_done_o (count_done),
        .result_o     (result)
    );

endmodule

// File: tb/tb_multiplier_iter_32b.sv
module tb_multiplier_iter_32b;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multiplier_iter_32b_if mif ();

    multiplier_iter_32b dut (
        .clk (clk),
        .rst (rst),
        .io  (mif)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer operands from a negedge; returns on the negedge after the transfer.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        bit          ok;
        ok = 0;
        mif.in0         = a;
        mif.in1         = b;
        mif.istream_val = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (mif.istream_rdy) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("send_accept", {31'd0, ok}, 32'd1);
        if (ok) begin
            p = a * b;
            exp_q.push_back(p);
            @(posedge clk);
        end
        @(negedge clk);
        mif.istream_val = 1'b0;
        mif.in0         = 32'hDEAD_BEEF;
        mif.in1         = 32'hCAFE_F00D;
    endtask

    task automatic pop_chk(input string tag);
        total++;
        assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL %s_spurious observed=output expected=no_output", tag);
        end
        if (exp_q.size() > 0) chk(tag, mif.out, exp_q.pop_front());
    endtask

    // Wait for a product, take it, return on the negedge after the transfer.
    task automatic recv(input string tag);
        bit got;
        got = 0;
        mif.ostream_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (mif.ostream_val) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_timeout"}, {31'd0, got}, 32'd1);
        if (got) pop_chk(tag);
        @(negedge clk);
        mif.ostream_rdy = 1'b0;
    endtask

    task automatic latency(input string tag);
        int lat;
        lat = 1;
        #1;
        while (!mif.ostream_val && lat < 100) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk(tag, lat, 32'd33);
    endtask

    initial begin
        logic [31:0] hold;
        bit          seen;
        bit          got;
        int          nrecv;

        mif.istream_val = 1'b0;
        mif.ostream_rdy = 1'b0;
        mif.in0         = '0;
        mif.in1         = '0;

        // Reset
        repeat (2) @(negedge clk);
        #1;
        chk("rst_irdy", {31'd0, mif.istream_rdy}, 32'd0);
        chk("rst_oval", {31'd0, mif.ostream_val}, 32'd0);
        chk("rst_out", mif.out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_irdy", {31'd0, mif.istream_rdy}, 32'd1);
        @(negedge clk);

        // Basic with latency check
        send(32'd3, 32'd4);
        latency("lat_basic");
        recv("basic");

        // Wrap and signed cases
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        recv("wrap_ff");
        send(32'h8000_0000, 32'd2);
        recv("wrap_80");
        send(32'hFFFF_FFFD, 32'd5);
        recv("signed");
        send(32'd0, 32'h1234_5678);
        latency("lat_zero");
        recv("zero");

        // Backpressure in DONE
        send(32'h0000_1234, 32'h0000_5678);
        latency("lat_bp");
        hold = mif.out;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("bp_out", mif.out, hold);
            chk("bp_irdy", {31'd0, mif.istream_rdy}, 32'd0);
            chk("bp_oval", {31'd0, mif.ostream_val}, 32'd1);
        end
        mif.ostream_rdy = 1'b1;
        pop_chk("bp");
        @(negedge clk);
        mif.ostream_rdy = 1'b0;
        #1;
        chk("bp_idle_irdy", {31'd0, mif.istream_rdy}, 32'd1);
        chk("bp_idle_oval", {31'd0, mif.ostream_val}, 32'd0);
        @(negedge clk);

        // Reset in the middle of CALC
        send(32'd9, 32'd9);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_irdy", {31'd0, mif.istream_rdy}, 32'd0);
        chk("midrst_oval", {31'd0, mif.ostream_val}, 32'd0);
        chk("midrst_out", mif.out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_front());
        #1;
        chk("midrst_after_irdy", {31'd0, mif.istream_rdy}, 32'd1);
        seen = 0;
        mif.ostream_rdy = 1'b1;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (mif.ostream_val) seen = 1;
        end
        mif.ostream_rdy = 1'b0;
        chk("midrst_no_oval", {31'd0, seen}, 32'd0);
        @(negedge clk);
        send(32'd7, 32'd6);
        recv("after_rst");

        // Random back-to-back traffic with val/rdy gaps
        nrecv = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send($urandom, $urandom);
                end
            end
            begin
                for (int c = 0; c < 30000 && nrecv < 100; c++) begin
                    @(negedge clk);
                    mif.ostream_rdy = ($urandom_range(0, 3) != 0);
                    #1;
                    if (mif.ostream_val && mif.ostream_rdy) begin
                        pop_chk("rand");
                        nrecv++;
                    end
                end
                mif.ostream_rdy = 1'b0;
            end
        join
        chk("rand_count", nrecv, 32'd100);
        chk("rand_queue_empty", exp_q.size(), 32'd0);

        // Nothing further may appear once all products are drained
        got = 0;
        mif.ostream_rdy = 1'b1;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (mif.ostream_val) got = 1;
        end
        chk("drain_no_oval", {31'd0, got}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
